// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencing controller:
//   - default widths (DATA_W_DEF, OPC_W_DEF)
//   - opcode values OP_NOP .. OP_CLC (0xC-0xF are illegal)
//   - FSM state encoding (state_t)
//   - ALU sub-op codes for alu_sel_1 (logic group)
//   - alu_sel_t: the bundle of ALU select lines driven by the controller
// Optional feature macro used by alu_ctrl: ZERO_FLAG_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OPC_W_DEF  = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_LDA = 4'hA;
    localparam logic [3:0] OP_CLC = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // alu_sel_1 codes; arithmetic ops use 00 with alu_sel_0 = 0
    localparam logic [1:0] SEL1_AND = 2'b00;
    localparam logic [1:0] SEL1_OR  = 2'b01;
    localparam logic [1:0] SEL1_XOR = 2'b10;
    localparam logic [1:0] SEL1_NOT = 2'b11;

    typedef struct packed {
        logic       cf_sel;
        logic       alu_sel_0;
        logic [1:0] alu_sel_1;
        logic       inv_sel;
        logic       shftr_sel;
        logic       shftl_sel;
    } alu_sel_t;

    localparam alu_sel_t SEL_NONE = '0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational opcode decoder.
// Ports:
//   opcode_i    in   OPC_W   opcode to decode
//   sel_o       out  struct  ALU select bundle for this opcode
//   wr_acc_o    out  1       accumulator takes the ALU result
//   wr_carry_o  out  1       carry flag takes the ALU carry out
//   ld_imm_o    out  1       accumulator takes the immediate (LDA)
//   clr_c_o     out  1       carry flag is cleared (CLC)
//   illegal_o   out  1       opcode is not defined
// -----------------------------------------------------------------------------
module alu_ctrl_dec
    import alu_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opcode_i,
    output alu_sel_t         sel_o,
    output logic             wr_acc_o,
    output logic             wr_carry_o,
    output logic             ld_imm_o,
    output logic             clr_c_o,
    output logic             illegal_o
);

    always_comb begin
        sel_o      = SEL_NONE;
        wr_acc_o   = 1'b0;
        wr_carry_o = 1'b0;
        ld_imm_o   = 1'b0;
        clr_c_o    = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_NOP: ;
            OP_ADD: begin
                wr_acc_o   = 1'b1;
                wr_carry_o = 1'b1;
            end
            OP_ADC: begin
                sel_o.cf_sel = 1'b1;
                wr_acc_o     = 1'b1;
                wr_carry_o   = 1'b1;
            end
            // Subtract is add of the inverted operand with the carry flag as carry-in
            OP_SUB: begin
                sel_o.cf_sel  = 1'b1;
                sel_o.inv_sel = 1'b1;
                wr_acc_o      = 1'b1;
                wr_carry_o    = 1'b1;
            end
            OP_AND: begin
                sel_o.alu_sel_0 = 1'b1;
                sel_o.alu_sel_1 = SEL1_AND;
                wr_acc_o        = 1'b1;
            end
            OP_OR: begin
                sel_o.alu_sel_0 = 1'b1;
                sel_o.alu_sel_1 = SEL1_OR;
                wr_acc_o        = 1'b1;
            end
            OP_XOR: begin
                sel_o.alu_sel_0 = 1'b1;
                sel_o.alu_sel_1 = SEL1_XOR;
                wr_acc_o        = 1'b1;
            end
            OP_NOT: begin
                sel_o.alu_sel_0 = 1'b1;
                sel_o.alu_sel_1 = SEL1_NOT;
                wr_acc_o        = 1'b1;
            end
            OP_SHR: begin
                sel_o.shftr_sel = 1'b1;
                wr_acc_o        = 1'b1;
                wr_carry_o      = 1'b1;
            end
            OP_SHL: begin
                sel_o.shftl_sel = 1'b1;
                wr_acc_o        = 1'b1;
                wr_carry_o      = 1'b1;
            end
            OP_LDA:  ld_imm_o  = 1'b1;
            OP_CLC:  clr_c_o   = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Sequencing controller on the driving side of the ALU select interface.
// One instruction per valid/ready handshake; IDLE -> EXEC -> DONE -> IDLE.
//
// Handshake: an instruction transfers on a rising edge where instr_valid_i and
// instr_ready_o are both 1. instr_ready_o is 1 only in IDLE; instr_valid_i is
// ignored in any other state, so a held valid is taken on the next IDLE cycle.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   instr_valid_i/ready_o   instruction handshake
//   opcode_i, imm_i         instruction, sampled on handshake
//   alu_result_i, cf_i      ALU result and carry out (combinational)
//   cf_sel_o, alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o
//                           ALU selects, driven only during EXEC
//   oprnd_0_o, oprnd_1_o    accumulator and latched immediate
//   acc_o, carry_o, zf_o    architectural registers
//   done_o, err_o           one-cycle retire pulse / illegal-opcode pulse
//   dbg_state_o             current FSM state
// Macro ZERO_FLAG_EN: when defined, zf_o is a register updated with every
// accumulator write; otherwise zf_o is tied to 0.
// -----------------------------------------------------------------------------
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              cf_i,
    output logic              cf_sel_o,
    output logic              alu_sel_0_o,
    output logic [1:0]        alu_sel_1_o,
    output logic              inv_sel_o,
    output logic              shftr_sel_o,
    output logic              shftl_sel_o,
    output logic [DATA_W-1:0] oprnd_0_o,
    output logic [DATA_W-1:0] oprnd_1_o,
    output logic [DATA_W-1:0] acc_o,
    output logic              carry_o,
    output logic              zf_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    state_t            r_state;
    alu_sel_t          r_sel;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_imm;
    logic              r_carry;
    logic              r_wr_acc;
    logic              r_wr_carry;
    logic              r_ld_imm;
    logic              r_clr_c;
    logic              r_illegal;
    logic              r_done;
    logic              r_err;

    alu_sel_t          w_dec_sel;
    logic              w_dec_wr_acc;
    logic              w_dec_wr_carry;
    logic              w_dec_ld_imm;
    logic              w_dec_clr_c;
    logic              w_dec_illegal;
    logic              w_acc_we;
    logic [DATA_W-1:0] w_acc_next;

    alu_ctrl_dec #(.OPC_W(OPC_W)) u_dec (
        .opcode_i   (opcode_i),
        .sel_o      (w_dec_sel),
        .wr_acc_o   (w_dec_wr_acc),
        .wr_carry_o (w_dec_wr_carry),
        .ld_imm_o   (w_dec_ld_imm),
        .clr_c_o    (w_dec_clr_c),
        .illegal_o  (w_dec_illegal)
    );

    // The accumulator value committed at the end of EXEC
    assign w_acc_we   = r_wr_acc | r_ld_imm;
    assign w_acc_next = r_ld_imm ? r_imm : alu_result_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_NONE;
            r_acc      <= '0;
            r_imm      <= '0;
            r_carry    <= 1'b0;
            r_wr_acc   <= 1'b0;
            r_wr_carry <= 1'b0;
            r_ld_imm   <= 1'b0;
            r_clr_c    <= 1'b0;
            r_illegal  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        r_imm      <= imm_i;
                        r_sel      <= w_dec_sel;
                        r_wr_acc   <= w_dec_wr_acc;
                        r_wr_carry <= w_dec_wr_carry;
                        r_ld_imm   <= w_dec_ld_imm;
                        r_clr_c    <= w_dec_clr_c;
                        r_illegal  <= w_dec_illegal;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_acc_we) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_wr_carry) begin
                        r_carry <= cf_i;
                    end else if (r_clr_c) begin
                        r_carry <= 1'b0;
                    end
                    r_sel   <= SEL_NONE;
                    r_done  <= 1'b1;
                    r_err   <= r_illegal;
                    r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ZERO_FLAG_EN
    logic r_zf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_zf <= 1'b0;
        end else if (r_state == ST_EXEC && w_acc_we) begin
            r_zf <= (w_acc_next == '0);
        end
    end

    assign zf_o = r_zf;
`else
    assign zf_o = 1'b0;
`endif

    assign instr_ready_o = (r_state == ST_IDLE);
    assign cf_sel_o      = r_sel.cf_sel;
    assign alu_sel_0_o   = r_sel.alu_sel_0;
    assign alu_sel_1_o   = r_sel.alu_sel_1;
    assign inv_sel_o     = r_sel.inv_sel;
    assign shftr_sel_o   = r_sel.shftr_sel;
    assign shftl_sel_o   = r_sel.shftl_sel;
    assign oprnd_0_o     = r_acc;
    assign oprnd_1_o     = r_imm;
    assign acc_o         = r_acc;
    assign carry_o       = r_carry;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl
// Bench for alu_ctrl. A small ALU built from the DUT select lines feeds
// alu_result_i/cf_i; an instruction-level model computes what acc/carry/zf
// must become from each opcode's meaning, and the expected acc of every
// retired instruction is queued for comparison at done_o.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         instr_valid_i;
  logic         instr_ready_o;
  logic [3:0]   opcode_i;
  logic [W-1:0] imm_i;
  logic [W-1:0] alu_result_i;
  logic         cf_i;
  logic         cf_sel_o, alu_sel_0_o, inv_sel_o, shftr_sel_o, shftl_sel_o;
  logic [1:0]   alu_sel_1_o;
  logic [W-1:0] oprnd_0_o, oprnd_1_o, acc_o;
  logic         carry_o, zf_o, done_o, err_o;
  logic [1:0]   dbg_state_o;

  alu_ctrl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .opcode_i      (opcode_i),
    .imm_i         (imm_i),
    .alu_result_i  (alu_result_i),
    .cf_i          (cf_i),
    .cf_sel_o      (cf_sel_o),
    .alu_sel_0_o   (alu_sel_0_o),
    .alu_sel_1_o   (alu_sel_1_o),
    .inv_sel_o     (inv_sel_o),
    .shftr_sel_o   (shftr_sel_o),
    .shftl_sel_o   (shftl_sel_o),
    .oprnd_0_o     (oprnd_0_o),
    .oprnd_1_o     (oprnd_1_o),
    .acc_o         (acc_o),
    .carry_o       (carry_o),
    .zf_o          (zf_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // external ALU driven by the controller's selects
  logic [8:0] b_sum;
  always_comb begin
    b_sum        = '0;
    alu_result_i = '0;
    cf_i         = 1'b0;
    if (shftr_sel_o) begin
      alu_result_i = oprnd_0_o >> 1;
      cf_i         = oprnd_0_o[0];
    end else if (shftl_sel_o) begin
      alu_result_i = oprnd_0_o << 1;
      cf_i         = oprnd_0_o[W-1];
    end else if (alu_sel_0_o) begin
      case (alu_sel_1_o)
        2'b00:   alu_result_i = oprnd_0_o & oprnd_1_o;
        2'b01:   alu_result_i = oprnd_0_o | oprnd_1_o;
        2'b10:   alu_result_i = oprnd_0_o ^ oprnd_1_o;
        default: alu_result_i = ~oprnd_0_o;
      endcase
    end else begin
      b_sum = {1'b0, oprnd_0_o} + {1'b0, (inv_sel_o ? ~oprnd_1_o : oprnd_1_o)}
              + {8'd0, (cf_sel_o & carry_o)};
      alu_result_i = b_sum[W-1:0];
      cf_i         = b_sum[W];
    end
  end

  // counters and scoreboard
  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  int acc_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // select lines each opcode must raise, {cf_sel, sel0, sel1[1:0], inv, shr, shl}
  function automatic logic [6:0] exp_sel(input logic [3:0] op);
    case (op)
      4'h2:    return 7'b1_0_00_0_0_0;
      4'h3:    return 7'b1_0_00_1_0_0;
      4'h4:    return 7'b0_1_00_0_0_0;
      4'h5:    return 7'b0_1_01_0_0_0;
      4'h6:    return 7'b0_1_10_0_0_0;
      4'h7:    return 7'b0_1_11_0_0_0;
      4'h8:    return 7'b0_0_00_0_1_0;
      4'h9:    return 7'b0_0_00_0_0_1;
      default: return 7'b0;
    endcase
  endfunction

  // instruction-level reference model
  int         m_busy;   // cycles since accept: 0 free, 1 executing, 2 retiring
  logic [3:0] m_op;
  logic [W-1:0] m_acc, m_imm;
  logic       m_c, m_zf, m_done, m_err;
  logic [8:0] t9;
  bit         wa;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_busy = 0; m_op = 0; m_acc = 0; m_imm = 0;
      m_c = 0; m_zf = 0; m_done = 0; m_err = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_done = 0;
      m_err  = 0;
      if (m_busy == 0) begin
        if (instr_valid_i) begin
          m_op   = opcode_i;
          m_imm  = imm_i;
          m_busy = 1;
          acc_cyc_q.push_back(cyc);
        end
      end else if (m_busy == 1) begin
        wa = 1;
        case (m_op)
          4'h1: begin t9 = {1'b0, m_acc} + {1'b0, m_imm}; m_acc = t9[7:0]; m_c = t9[8]; end
          4'h2: begin t9 = {1'b0, m_acc} + {1'b0, m_imm} + {8'd0, m_c}; m_acc = t9[7:0]; m_c = t9[8]; end
          4'h3: begin t9 = {1'b0, m_acc} + {1'b0, ~m_imm} + {8'd0, m_c}; m_acc = t9[7:0]; m_c = t9[8]; end
          4'h4: m_acc = m_acc & m_imm;
          4'h5: m_acc = m_acc | m_imm;
          4'h6: m_acc = m_acc ^ m_imm;
          4'h7: m_acc = ~m_acc;
          4'h8: begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
          4'h9: begin m_c = m_acc[7]; m_acc = m_acc << 1; end
          4'hA: m_acc = m_imm;
          4'hB: begin m_c = 0; wa = 0; end
          default: wa = 0;
        endcase
        if (wa) m_zf = (m_acc == 0);
        exp_q.push_back(m_acc);
        m_done = 1;
        m_err  = (m_op >= 4'hC);
        m_busy = 2;
      end else begin
        m_busy = 0;
      end
    end
  end

  // compare process: every cycle out of reset
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      check("ready", instr_ready_o, m_busy == 0);
      check("selects", {cf_sel_o, alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o},
            (m_busy == 1) ? exp_sel(m_op) : 7'b0);
      check("oprnd_0", oprnd_0_o, m_acc);
      check("oprnd_1", oprnd_1_o, m_imm);
      check("acc", acc_o, m_acc);
      check("carry", carry_o, m_c);
`ifdef ZERO_FLAG_EN
      check("zf", zf_o, m_zf);
`else
      check("zf", zf_o, 1'b0);
`endif
      check("done", done_o, m_done);
      check("err", err_o, m_err);
      if (done_o) begin
        n_done++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_acc: got done with acc 0x%0h, expected no retire", acc_o);
        end else begin
          check("sb_acc", acc_o, exp_q.pop_front());
        end
      end
    end
  end

  // driver: present an instruction from a negedge and wait for its transfer
  task automatic issue(input logic [3:0] op, input logic [W-1:0] imm, input bit hold);
    int k;
    k = 0;
    instr_valid_i = 1'b1;
    opcode_i      = op;
    imm_i         = imm;
    while (!instr_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    n_checks++;
    if (k >= 20) begin
      n_err++;
      $display("FAIL accept_timeout: waited %0d cycles, required under 20", k);
    end
    @(negedge clk_i);
    if (!hold) instr_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done_o && k < 10) begin
      @(negedge clk_i);
      k++;
    end
    n_checks++;
    if (k >= 10) begin
      n_err++;
      $display("FAIL done_timeout: waited %0d cycles, required under 10", k);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  int d0;
  int gap;

  initial begin
    instr_valid_i = 1'b0;
    opcode_i      = '0;
    imm_i         = '0;
    repeat (3) @(negedge clk_i);
    check("rst_acc", acc_o, 8'h00);
    check("rst_carry", carry_o, 1'b0);
    check("rst_ready", instr_ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);

    // LDA 0x7F then ADD 0x01
    issue(OP_LDA, 8'h7F, 0);
    issue(OP_ADD, 8'h01, 0);
    @(negedge clk_i);
    check("add_acc", acc_o, 8'h80);
    check("add_carry", carry_o, 1'b0);
    check("add_done", done_o, 1'b1);
    check("add_ready_done", instr_ready_o, 1'b0);
    @(negedge clk_i);

    // wrap: 0xFF + 0x01
    issue(OP_LDA, 8'hFF, 0);
    issue(OP_ADD, 8'h01, 0);
    @(negedge clk_i);
    check("wrap_acc", acc_o, 8'h00);
    check("wrap_carry", carry_o, 1'b1);
`ifdef ZERO_FLAG_EN
    check("wrap_zf", zf_o, 1'b1);
`endif
    @(negedge clk_i);

    // illegal opcode leaves acc and carry alone
    issue(OP_LDA, 8'h55, 0);
    issue(4'hE, 8'h12, 0);
    @(negedge clk_i);
    check("ill_done", done_o, 1'b1);
    check("ill_err", err_o, 1'b1);
    check("ill_acc", acc_o, 8'h55);
    check("ill_carry", carry_o, 1'b1);
    @(negedge clk_i);

    // SUB selects during execution
    issue(OP_SUB, 8'h10, 0);
    check("sub_sel", {inv_sel_o, cf_sel_o, alu_sel_0_o, alu_sel_1_o}, 5'b11000);
    wait_done();
    @(negedge clk_i);

    // async reset in the middle of execution
    issue(OP_ADD, 8'h33, 0);
    #1 rst_n_i = 1'b0;
    #1;
    check("mid_rst_acc", acc_o, 8'h00);
    check("mid_rst_carry", carry_o, 1'b0);
    check("mid_rst_zf", zf_o, 1'b0);
    check("mid_rst_sel", {cf_sel_o, alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o}, 7'b0);
    check("mid_rst_imm", oprnd_1_o, 8'h00);
    check("mid_rst_ready", instr_ready_o, 1'b1);
    d0 = n_done;
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("mid_rst_no_done", n_done - d0, 0);

    // back-to-back with valid held
    acc_cyc_q.delete();
    d0 = n_done;
    issue(OP_LDA, 8'h21, 1);
    issue(OP_ADC, 8'h42, 1);
    issue(OP_SHL, 8'h00, 0);
    wait_done();
    @(negedge clk_i);
    check("b2b_accepts", acc_cyc_q.size(), 3);
    if (acc_cyc_q.size() == 3) begin
      check("b2b_gap1", acc_cyc_q[1] - acc_cyc_q[0], 3);
      check("b2b_gap2", acc_cyc_q[2] - acc_cyc_q[1], 3);
    end
    check("b2b_dones", n_done - d0, 3);
    check("b2b_acc", acc_o, 8'hC6);

    // random instruction stream
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        instr_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
      end
      issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end
    instr_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
